// File: rtl/brushless_commutator.sv
// Hall-sensor six-step commutator for a brushless assist motor: synchronised halls and brake
// drive registered per-phase selects and duty. Optional stall detection under BRUSHLESS_STALL_DET_EN.
`timescale 1ns/1ps
module brushless_commutator
`ifdef BRUSHLESS_STALL_DET_EN
#(
    parameter int unsigned STALL_PWMS = 512
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] drv_mag,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu
`ifdef BRUSHLESS_STALL_DET_EN
    ,
    output logic        stall
`endif
);

    localparam int unsigned DUTY_W = 11;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ROT_W  = 3;

    localparam logic [SEL_W-1:0]  SEL_COAST = 2'b00;
    localparam logic [SEL_W-1:0]  SEL_REV   = 2'b01;
    localparam logic [SEL_W-1:0]  SEL_FWD   = 2'b10;
    localparam logic [SEL_W-1:0]  SEL_BRAKE = 2'b11;

    localparam logic [DUTY_W-1:0] DUTY_BASE  = 11'h400;
    localparam logic [DUTY_W-1:0] DUTY_BRAKE = 11'h600;

    logic [ROT_W-1:0]    r_hall_meta;
    logic [ROT_W-1:0]    r_hall_sync;
    logic                r_brk_meta;
    logic                r_brk_sync;
    logic [ROT_W-1:0]    r_rot;
    logic [3*SEL_W-1:0]  r_sel;
    logic [DUTY_W-1:0]   r_duty;

    logic [3*SEL_W-1:0]  w_sel;
    logic [DUTY_W-1:0]   w_duty;
    logic                w_mag_zero;
    logic                w_stall;

    assign w_mag_zero = (drv_mag == 12'h000);

    // Two-flop synchronisers; brake resets to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hall_meta <= '0;
            r_hall_sync <= '0;
            r_brk_meta  <= 1'b1;
            r_brk_sync  <= 1'b1;
        end else begin
            r_hall_meta <= {hallBlu, hallYlw, hallGrn};
            r_hall_sync <= r_hall_meta;
            r_brk_meta  <= brake_n;
            r_brk_sync  <= r_brk_meta;
        end
    end

    // Rotor position only sampled at the drive stage's quiet point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot <= '0;
        end else if (PWM_synch) begin
            r_rot <= r_hall_sync;
        end
    end

`ifdef BRUSHLESS_STALL_DET_EN
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_PWMS);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stall;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_clr;

    assign w_cnt_clr = (PWM_synch && (r_hall_sync != r_rot)) || w_mag_zero || !r_brk_sync;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (PWM_synch && (r_cnt != CNT_LIMIT)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Stall flag tracks the saturated counter exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_stall <= (w_cnt_nxt == CNT_LIMIT);
        end
    end

    assign w_stall = r_stall;
    assign stall   = r_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Commutation table, then zero-demand/stall coast, then brake override.
    always_comb begin
        w_sel = {SEL_COAST, SEL_COAST, SEL_COAST};
        unique case (r_rot)
            3'b101:  w_sel = {SEL_FWD,   SEL_REV,   SEL_COAST};
            3'b100:  w_sel = {SEL_FWD,   SEL_COAST, SEL_REV};
            3'b110:  w_sel = {SEL_COAST, SEL_FWD,   SEL_REV};
            3'b010:  w_sel = {SEL_REV,   SEL_FWD,   SEL_COAST};
            3'b011:  w_sel = {SEL_REV,   SEL_COAST, SEL_FWD};
            3'b001:  w_sel = {SEL_COAST, SEL_REV,   SEL_FWD};
            default: w_sel = {SEL_COAST, SEL_COAST, SEL_COAST};
        endcase
        if (w_mag_zero || w_stall) begin
            w_sel = {SEL_COAST, SEL_COAST, SEL_COAST};
        end
        if (!r_brk_sync) begin
            w_sel = {SEL_BRAKE, SEL_BRAKE, SEL_BRAKE};
        end
    end

    always_comb begin
        w_duty = DUTY_BASE + DUTY_W'(drv_mag[11:2]);
        if (!r_brk_sync) begin
            w_duty = DUTY_BRAKE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_duty <= DUTY_BASE;
        end else begin
            r_sel  <= w_sel;
            r_duty <= w_duty;
        end
    end

    assign selGrn = r_sel[5:4];
    assign selYlw = r_sel[3:2];
    assign selBlu = r_sel[1:0];
    assign duty   = r_duty;

endmodule
